// File: rtl/mr_cmd_sequencer.sv
// Mode-register MRW/MRR command sequencer: waits for an idle command bus, issues one
// command, enforces tMRW/tMRR spacing and pulses done. Optional feature: MRR_TIMEOUT_EN.
module mr_cmd_sequencer #(
  parameter  int NB_RANK         = 2,
  parameter  int TMRW_CYC        = 10,
  parameter  int TMRR_CYC        = 8,
  parameter  int MRR_TIMEOUT_CYC = 1024,
  localparam int RANK_W          = $clog2(NB_RANK)
) (
  input  logic              pclk_i,
  input  logic              prst_ni,
  input  logic              mrw_req_i,
  input  logic              mrr_req_i,
  input  logic [7:0]        mr_addr_i,
  input  logic [7:0]        mr_data_i,
  input  logic [RANK_W-1:0] rank_idx_i,
  input  logic              mc_idle_i,
  output logic              cmd_valid_o,
  input  logic              cmd_ready_i,
  output logic [1:0]        cmd_type_o,
  output logic [RANK_W-1:0] cmd_rank_o,
  output logic [7:0]        cmd_addr_o,
  output logic [7:0]        cmd_data_o,
  input  logic              rd_valid_i,
  input  logic [7:0]        rd_data_i,
  output logic              busy_o,
  output logic              mrw_done_o,
  output logic              mrr_done_o,
  output logic [7:0]        mrr_data_o,
  output logic              err_o
);

  typedef enum logic [2:0] {IDLE, WAIT_MC, ISSUE, MRW_GAP, MRR_WAIT, DONE} state_t;

  state_t            state, state_n;
  logic              op_mrr;
  logic [7:0]        cnt, cnt_n;
  logic              captured;
  logic [7:0]        mrr_data;
  logic [7:0]        lat_addr, lat_data;
  logic [RANK_W-1:0] lat_rank;
  logic              latch, capture, accept;

`ifdef MRR_TIMEOUT_EN
  logic [15:0] to_cnt;
  logic        timeout;
  logic        err_flag;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (MRR_TIMEOUT_CYC != 0);
`endif

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    latch       = 1'b0;
    capture     = 1'b0;
    accept      = 1'b0;
    cmd_valid_o = 1'b0;
`ifdef MRR_TIMEOUT_EN
    timeout     = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (mrw_req_i || mrr_req_i) begin
          latch   = 1'b1;
          state_n = WAIT_MC;
        end
      end
      WAIT_MC: if (mc_idle_i) state_n = ISSUE;
      ISSUE: begin
        cmd_valid_o = 1'b1;
        if (cmd_ready_i) begin
          accept  = 1'b1;
          cnt_n   = op_mrr ? 8'(TMRR_CYC - 1) : 8'(TMRW_CYC - 1);
          state_n = op_mrr ? MRR_WAIT : MRW_GAP;
        end
      end
      MRW_GAP: begin
        if (cnt == 8'd0) state_n = DONE;
        else             cnt_n   = cnt - 8'd1;
      end
      MRR_WAIT: begin
        if (cnt != 8'd0) cnt_n = cnt - 8'd1;
        if (!captured && rd_valid_i) capture = 1'b1;
        // A beat in the cycle the spacing expires completes without an extra cycle
        if ((captured || rd_valid_i) && cnt == 8'd0) state_n = DONE;
`ifdef MRR_TIMEOUT_EN
        else if (!captured && !rd_valid_i && to_cnt == 16'd0) begin
          timeout = 1'b1;
          state_n = DONE;
        end
`endif
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge pclk_i or negedge prst_ni) begin
    if (!prst_ni) begin
      state    <= IDLE;
      op_mrr   <= 1'b0;
      cnt      <= 8'd0;
      captured <= 1'b0;
      mrr_data <= 8'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (latch) begin
        op_mrr   <= !mrw_req_i;
        captured <= 1'b0;
      end
      if (capture) begin
        captured <= 1'b1;
        mrr_data <= rd_data_i;
      end
`ifdef MRR_TIMEOUT_EN
      else if (timeout) mrr_data <= 8'hFF;
`endif
    end
  end

  // Command fields need no reset: they are only visible while cmd_valid_o is high
  always_ff @(posedge pclk_i) begin
    if (latch) begin
      lat_addr <= mr_addr_i;
      lat_data <= mr_data_i;
      lat_rank <= rank_idx_i;
    end
  end

`ifdef MRR_TIMEOUT_EN
  always_ff @(posedge pclk_i or negedge prst_ni) begin
    if (!prst_ni) begin
      to_cnt   <= 16'd0;
      err_flag <= 1'b0;
    end else begin
      if (accept)                                to_cnt <= 16'(MRR_TIMEOUT_CYC - 1);
      else if (state == MRR_WAIT && to_cnt != 0) to_cnt <= to_cnt - 16'd1;
      if (latch)        err_flag <= 1'b0;
      else if (timeout) err_flag <= 1'b1;
    end
  end
  assign err_o = (state == DONE) && err_flag;
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign err_o = 1'b0;
`endif

  assign cmd_type_o = cmd_valid_o ? (op_mrr ? 2'b10 : 2'b01) : 2'b00;
  assign cmd_addr_o = cmd_valid_o ? lat_addr : 8'd0;
  assign cmd_data_o = cmd_valid_o ? lat_data : 8'd0;
  assign cmd_rank_o = cmd_valid_o ? lat_rank : '0;
  assign busy_o     = (state != IDLE);
  assign mrw_done_o = (state == DONE) && !op_mrr;
  assign mrr_done_o = (state == DONE) && op_mrr;
  assign mrr_data_o = mrr_data;

endmodule

// File: tb/tb_mr_cmd_sequencer.sv
// Bench for mr_cmd_sequencer: directed vector table, randomized operations against a
// latency/data reference model, and a mid-operation reset sequence.
module tb_mr_cmd_sequencer;
  localparam int TMRW = 10;
  localparam int TMRR = 8;
  localparam int TO   = 64;

  logic       pclk = 1'b0;
  logic       prst_ni;
  logic       mrw_req, mrr_req, mc_idle, cmd_ready, rd_valid;
  logic [7:0] mr_addr, mr_data, rd_data;
  logic [0:0] rank_idx;
  logic       cmd_valid, busy, mrw_done, mrr_done, err;
  logic [1:0] cmd_type;
  logic [0:0] cmd_rank;
  logic [7:0] cmd_addr, cmd_data, mrr_data;

  always #5 pclk = ~pclk;

  mr_cmd_sequencer #(.NB_RANK(2), .TMRW_CYC(TMRW), .TMRR_CYC(TMRR), .MRR_TIMEOUT_CYC(TO)) dut (
    .pclk_i(pclk), .prst_ni(prst_ni), .mrw_req_i(mrw_req), .mrr_req_i(mrr_req),
    .mr_addr_i(mr_addr), .mr_data_i(mr_data), .rank_idx_i(rank_idx), .mc_idle_i(mc_idle),
    .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready), .cmd_type_o(cmd_type),
    .cmd_rank_o(cmd_rank), .cmd_addr_o(cmd_addr), .cmd_data_o(cmd_data),
    .rd_valid_i(rd_valid), .rd_data_i(rd_data), .busy_o(busy), .mrw_done_o(mrw_done),
    .mrr_done_o(mrr_done), .mrr_data_o(mrr_data), .err_o(err));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit         req_w, req_r, busy_req, extra;
    logic [7:0] addr, data;
    logic [0:0] rank;
    int         idle_dly, stall, rd_dly;
    logic [7:0] rd_byte;
    int         exp_lat;
    logic [7:0] exp_rdata;
    bit         exp_err;
  } vec_t;

  vec_t tbl[$];
  logic [7:0] m_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  function automatic vec_t mk(bit w, bit r, bit br, bit ex, logic [7:0] a, logic [7:0] d,
                              logic [0:0] rk, int idl, int st, int rdd, logic [7:0] rb,
                              int lat, logic [7:0] erd, bit eerr);
    vec_t v;
    v.req_w = w; v.req_r = r; v.busy_req = br; v.extra = ex;
    v.addr = a; v.data = d; v.rank = rk; v.idle_dly = idl; v.stall = st;
    v.rd_dly = rdd; v.rd_byte = rb; v.exp_lat = lat; v.exp_rdata = erd; v.exp_err = eerr;
    return v;
  endfunction

  task automatic run_op(input vec_t v);
    int k;
    logic [1:0] etype;
    etype = v.req_w ? 2'b01 : 2'b10;
    chk("idle_before_req", busy, 1'b0);
    mrw_req = v.req_w; mrr_req = v.req_r;
    mr_addr = v.addr; mr_data = v.data; rank_idx = v.rank;
    mc_idle = 1'b0; cmd_ready = 1'b0;
    step();
    mrw_req = 1'b0; mrr_req = 1'b0;
    mr_addr = 8'($urandom); mr_data = 8'($urandom); rank_idx = 1'($urandom);
    chk("busy_after_req", busy, 1'b1);
    chk("no_cmd_in_wait", cmd_valid, 1'b0);
    for (int i = 0; i < v.idle_dly; i++) begin
      step();
      chk("no_cmd_before_idle", cmd_valid, 1'b0);
    end
    mc_idle = 1'b1;
    step();
    mc_idle = 1'b0;
    for (int s = 0; s <= v.stall; s++) begin
      chk("cmd_valid", cmd_valid, 1'b1);
      chk("cmd_type", cmd_type, etype);
      chk("cmd_addr", cmd_addr, v.addr);
      chk("cmd_data", cmd_data, v.data);
      chk("cmd_rank", cmd_rank, v.rank);
      cmd_ready = (s == v.stall);
      step();
    end
    cmd_ready = 1'b0;
    k = 1;
    while (k <= TO + 300) begin
      rd_valid = 1'b0;
      mrw_req = 1'b0;
      mrr_req = 1'b0;
      if (mrw_done || mrr_done) break;
      if (cmd_valid) chk("single_cmd", cmd_valid, 1'b0);
      if (v.busy_req && k == 1) begin mrw_req = 1'b1; mrr_req = 1'b1; end
      if (k == v.rd_dly) begin rd_valid = 1'b1; rd_data = v.rd_byte; end
      if (v.extra && v.rd_dly > 0 && k == v.rd_dly + 1) begin
        rd_valid = 1'b1; rd_data = ~v.rd_byte;
      end
      step();
      k++;
    end
    rd_valid = 1'b0;
    chk("done_latency", k, v.exp_lat);
    chk("mrw_done", mrw_done, v.req_w);
    chk("mrr_done", mrr_done, !v.req_w);
    chk("err", err, v.exp_err);
    chk("mrr_data", mrr_data, v.exp_rdata);
    step();
    chk("busy_after_done", busy, 1'b0);
    chk("done_one_cycle", mrw_done | mrr_done, 1'b0);
    mc_idle = 1'b1; cmd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("dropped_req_idle", busy | cmd_valid, 1'b0);
    end
    mc_idle = 1'b0; cmd_ready = 1'b0;
    m_rdata = v.exp_rdata;
  endtask

  initial begin
    vec_t v;
    int rdd, lat;
    prst_ni = 1'b0;
    mrw_req = 0; mrr_req = 0; mr_addr = 0; mr_data = 0; rank_idx = 0;
    mc_idle = 0; cmd_ready = 0; rd_valid = 0; rd_data = 0;
    step(); step();
    chk("rst_busy", busy, 1'b0);
    chk("rst_cmd_valid", cmd_valid, 1'b0);
    chk("rst_cmd_fields", {cmd_type, cmd_rank, cmd_addr, cmd_data}, 0);
    chk("rst_done", {mrw_done, mrr_done, err}, 0);
    chk("rst_mrr_data", mrr_data, 8'h00);
    prst_ni = 1'b1;
    step();

    //        w  r  br ex addr   data   rk idl st rd  rbyte  lat            rdata  err
    tbl.push_back(mk(1, 0, 0, 0, 8'h0D, 8'h5A, 1, 0, 0, -1, 8'h00, TMRW + 1, 8'h00, 0));
    tbl.push_back(mk(0, 1, 0, 0, 8'h05, 8'h00, 0, 0, 0, 3, 8'hA5, 9, 8'hA5, 0));
    tbl.push_back(mk(0, 1, 0, 1, 8'h08, 8'h00, 1, 0, 0, 12, 8'h3C, 13, 8'h3C, 0));
    tbl.push_back(mk(1, 0, 0, 0, 8'h11, 8'h22, 0, 20, 5, -1, 8'h00, TMRW + 1, 8'h3C, 0));
    tbl.push_back(mk(1, 1, 1, 0, 8'h01, 8'h02, 1, 1, 0, -1, 8'h00, TMRW + 1, 8'h3C, 0));
    tbl.push_back(mk(0, 1, 0, 0, 8'h20, 8'h00, 0, 0, 2, TMRR, 8'h77, TMRR + 1, 8'h77, 0));
    tbl.push_back(mk(0, 1, 0, 1, 8'h21, 8'h00, 1, 2, 0, 1, 8'h66, TMRR + 1, 8'h66, 0));
`ifdef MRR_TIMEOUT_EN
    tbl.push_back(mk(0, 1, 0, 0, 8'h30, 8'h00, 0, 0, 0, -1, 8'h00, TO + 1, 8'hFF, 1));
    tbl.push_back(mk(0, 1, 0, 0, 8'h31, 8'h00, 0, 0, 0, TO, 8'h4B, TO + 1, 8'h4B, 0));
`endif
    foreach (tbl[i]) run_op(tbl[i]);

    // Reference model: MRW done at accept+TMRW+1, MRR done at max(accept+TMRR, data)+1
    for (int n = 0; n < 40; n++) begin
      v.req_w = 1'($urandom);
      v.req_r = v.req_w ? 1'($urandom) : 1'b1;
      v.busy_req = 1'($urandom);
      v.extra = 1'($urandom);
      v.addr = 8'($urandom); v.data = 8'($urandom); v.rank = 1'($urandom);
      v.idle_dly = $urandom_range(0, 5);
      v.stall = $urandom_range(0, 4);
      rdd = $urandom_range(1, 15);
      v.rd_dly = v.req_w ? -1 : rdd;
      v.rd_byte = 8'($urandom);
      lat = (rdd > TMRR) ? rdd : TMRR;
      v.exp_lat = v.req_w ? TMRW + 1 : lat + 1;
      v.exp_rdata = v.req_w ? m_rdata : v.rd_byte;
      v.exp_err = 1'b0;
      run_op(v);
    end

    mrw_req = 1'b1; mr_addr = 8'h44; mr_data = 8'h55; rank_idx = 1'b1;
    mc_idle = 1'b1; cmd_ready = 1'b1;
    step();
    mrw_req = 1'b0;
    step();
    chk("rst_seq_cmd", cmd_valid, 1'b1);
    step(); step(); step(); step();
    chk("rst_seq_busy_pre", busy, 1'b1);
    prst_ni = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_outputs", {cmd_valid, cmd_type, cmd_addr, cmd_data, mrw_done, mrr_done, err}, 0);
    chk("midrst_mrr_data", mrr_data, 8'h00);
    step();
    prst_ni = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("no_done_after_rst", {busy, cmd_valid, mrw_done, mrr_done}, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
